// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the javk-cpu sequenced controller: opcodes, condition
// codes, ALU flag positions and controller state encodings.
package ctrl_seq_pkg;

   localparam int OPCODE_W              = 4;
   localparam int OPCODE_ARITHMETIC_BIT = 3;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Opcodes 0-7 are ALU operations; bit 3 set marks control/memory opcodes.
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_NOT = 4'd7,
      OP_JMP = 4'd8,
      OP_JPL = 4'd9,
      OP_MVA = 4'd10,
      OP_MVB = 4'd11,
      OP_LNL = 4'd12,
      OP_LNH = 4'd13,
      OP_LDB = 4'd14,
      OP_STB = 4'd15
   } opcode_e;

   typedef enum logic [3:0] {
      CC_EQ = 4'd0,
      CC_NE = 4'd1,
      CC_HS = 4'd2,
      CC_LO = 4'd3,
      CC_MI = 4'd4,
      CC_PL = 4'd5,
      CC_VS = 4'd6,
      CC_VC = 4'd7,
      CC_HI = 4'd8,
      CC_LS = 4'd9,
      CC_GE = 4'd10,
      CC_LT = 4'd11,
      CC_GT = 4'd12,
      CC_LE = 4'd13,
      CC_AL = 4'd14,
      CC_NV = 4'd15
   } cond_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } ctrl_state_e;

   function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
      return (op == OP_LDB) || (op == OP_STB);
   endfunction

endpackage

// File: rtl/ctrl_seq_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched
// ALU flags to a single taken/not-taken result.
module ctrl_seq_cond_eval
   import ctrl_seq_pkg::*;
#(
   parameter int FLAG_W = 4
) (
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] flags,
   output logic              result
);

   logic z;
   logic c;
   logic n;
   logic v;

   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];

   always_comb begin
      result = 1'b0;
      case (cond_e'(cond))
         CC_EQ: result = z;
         CC_NE: result = ~z;
         CC_HS: result = c;
         CC_LO: result = ~c;
         CC_MI: result = n;
         CC_PL: result = ~n;
         CC_VS: result = v;
         CC_VC: result = ~v;
         CC_HI: result = c & ~z;
         CC_LS: result = ~c | z;
         CC_GE: result = ~(n ^ v);
         CC_LT: result = n ^ v;
         CC_GT: result = ~z & ~(n ^ v);
         CC_LE: result = z | (n ^ v);
         CC_AL: result = 1'b1;
         CC_NV: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced FETCH/DECODE/EXEC/MEM controller with instruction register, flag
// latch, branch evaluation and a memory-timeout fault that parks in HALT.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int INSTR_W     = 8,
   parameter int FLAG_W      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [FLAG_W-1:0]  alu_flags,
   input  logic               mem_ack,
   output logic [2:0]         alu_op,
   output logic [3:0]         alu_shamt,
   output logic               alu_en,
   output logic [FLAG_W-1:0]  flags_q,
   output logic               branch,
   output logic               jmp,
   output logic               jpl,
   output logic               mva,
   output logic               mvb,
   output logic               nibble_read,
   output logic               nibble_hl,
   output logic [3:0]         nibble_out,
   output logic [3:0]         reg_sel,
   output logic [3:0]         addr_offset,
   output logic [1:0]         reg16_dst,
   output logic [1:0]         reg16_src,
   output logic               mem_req,
   output logic               we,
   output logic               pc_inc,
   output logic               fault
);

   localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
   // The MEM cycle that sees tcnt at this value is the last one allowed.
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

   ctrl_state_e         state_q;
   ctrl_state_e         state_d;
   logic [INSTR_W-1:0]  ir_q;
   logic [INSTR_W-1:0]  ir_d;
   logic [FLAG_W-1:0]   flags_d;
   logic [TCNT_W-1:0]   tcnt_q;
   logic [TCNT_W-1:0]   tcnt_d;
   logic                branch_q;
   logic                branch_d;
   logic                alu_upd_q;
   logic                alu_upd_d;

   logic [OPCODE_W-1:0] opcode;
   logic [3:0]          operand;
   logic                cond_res;

   assign opcode  = ir_q[INSTR_W-1 -: OPCODE_W];
   assign operand = ir_q[3:0];

   ctrl_seq_cond_eval #(
      .FLAG_W (FLAG_W)
   ) u_cond_eval (
      .cond   (operand),
      .flags  (flags_q),
      .result (cond_res)
   );

   // Operand slices are plain views of the instruction register.
   assign alu_op      = opcode[2:0];
   assign alu_shamt   = operand;
   assign nibble_out  = operand;
   assign reg_sel     = operand;
   assign addr_offset = operand;
   assign reg16_dst   = operand[3:2];
   assign reg16_src   = operand[1:0];
   assign nibble_hl   = (opcode == OP_LNH);
   assign branch      = branch_q;

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      tcnt_d      = tcnt_q;
      branch_d    = branch_q;
      instr_ready = 1'b0;
      alu_en      = 1'b0;
      jmp         = 1'b0;
      jpl         = 1'b0;
      mva         = 1'b0;
      mvb         = 1'b0;
      nibble_read = 1'b0;
      mem_req     = 1'b0;
      we          = 1'b0;
      pc_inc      = 1'b0;
      fault       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            branch_d = cond_res;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            alu_en      = ~opcode[OPCODE_ARITHMETIC_BIT];
            jmp         = (opcode == OP_JMP);
            jpl         = (opcode == OP_JPL);
            mva         = (opcode == OP_MVA);
            mvb         = (opcode == OP_MVB);
            nibble_read = (opcode == OP_LNL) || (opcode == OP_LNH);
            if (is_mem_op(opcode)) begin
               tcnt_d  = '0;
               state_d = ST_MEM;
            end else begin
               pc_inc  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            we      = (opcode == OP_STB);
            // An ack in the final allowed cycle still completes normally.
            if (mem_ack) begin
               pc_inc  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
               if (tcnt_q == TCNT_LAST) begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            fault = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // Flags are captured the cycle after the ALU strobe, when the ALU result is live.
      alu_upd_d = alu_en;
      flags_d   = alu_upd_q ? alu_flags : flags_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         ir_q      <= '0;
         flags_q   <= '0;
         tcnt_q    <= '0;
         branch_q  <= 1'b0;
         alu_upd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         tcnt_q    <= tcnt_d;
         branch_q  <= branch_d;
         alu_upd_q <= alu_upd_d;
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed scenarios plus randomized traffic
// compared every cycle against an instruction-level behavioural model.
module tb_ctrl_seq;

   localparam int INSTR_W     = 8;
   localparam int FLAG_W      = 4;
   localparam int MEM_TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       instr_valid = 1'b0;
   logic [3:0] alu_flags = 4'h0;
   logic       mem_ack = 1'b0;

   logic       instr_ready;
   logic [2:0] alu_op;
   logic [3:0] alu_shamt;
   logic       alu_en;
   logic [3:0] flags_q;
   logic       branch;
   logic       jmp, jpl, mva, mvb, nibble_read, nibble_hl;
   logic [3:0] nibble_out, reg_sel, addr_offset;
   logic [1:0] reg16_dst, reg16_src;
   logic       mem_req, we, pc_inc, fault;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic       instr_ready;
      logic       alu_en;
      logic       branch;
      logic       jmp;
      logic       jpl;
      logic       mva;
      logic       mvb;
      logic       nibble_read;
      logic       nibble_hl;
      logic       mem_req;
      logic       we;
      logic       pc_inc;
      logic       fault;
      logic [2:0] alu_op;
      logic [3:0] alu_shamt;
      logic [3:0] nibble_out;
      logic [3:0] reg_sel;
      logic [3:0] addr_offset;
      logic [1:0] reg16_dst;
      logic [1:0] reg16_src;
      logic [3:0] flags;
   } outs_t;

   outs_t act;
   assign act = {instr_ready, alu_en, branch, jmp, jpl, mva, mvb, nibble_read, nibble_hl,
                 mem_req, we, pc_inc, fault, alu_op, alu_shamt, nibble_out, reg_sel,
                 addr_offset, reg16_dst, reg16_src, flags_q};

   ctrl_seq #(
      .INSTR_W     (INSTR_W),
      .FLAG_W      (FLAG_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_flags   (alu_flags),
      .mem_ack     (mem_ack),
      .alu_op      (alu_op),
      .alu_shamt   (alu_shamt),
      .alu_en      (alu_en),
      .flags_q     (flags_q),
      .branch      (branch),
      .jmp         (jmp),
      .jpl         (jpl),
      .mva         (mva),
      .mvb         (mvb),
      .nibble_read (nibble_read),
      .nibble_hl   (nibble_hl),
      .nibble_out  (nibble_out),
      .reg_sel     (reg_sel),
      .addr_offset (addr_offset),
      .reg16_dst   (reg16_dst),
      .reg16_src   (reg16_src),
      .mem_req     (mem_req),
      .we          (we),
      .pc_inc      (pc_inc),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Flags: bit0 Z, bit1 C, bit2 N, bit3 V. Opcodes 0-7 ALU, 8 JMP, 9 JPL,
   // 10 MVA, 11 MVB, 12 LNL, 13 LNH, 14 LDB, 15 STB.
   // m_age counts cycles since the instruction was accepted.
   bit         m_halt = 1'b0;
   bit         m_busy = 1'b0;
   int         m_age = 0;
   logic [7:0] m_ir = 8'h00;
   logic [3:0] m_flags = 4'h0;
   bit         m_branch = 1'b0;
   bit         m_alu_prev = 1'b0;

   // Even codes test a predicate, the following odd code is its negation.
   function automatic bit cond_ref(input logic [3:0] cc, input logic [3:0] f);
      bit z, c, n, v, p;
      z = f[0]; c = f[1]; n = f[2]; v = f[3];
      case (cc[3:1])
         3'd0: p = z;
         3'd1: p = c;
         3'd2: p = n;
         3'd3: p = v;
         3'd4: p = c && !z;
         3'd5: p = (n == v);
         3'd6: p = !z && (n == v);
         default: p = 1'b1;
      endcase
      return cc[0] ? !p : p;
   endfunction

   function automatic bit model_alu_strobe();
      return !m_halt && m_busy && (m_age == 2) && (m_ir[7:4] < 4'd8);
   endfunction

   function automatic outs_t expect_now();
      outs_t o;
      logic [3:0] op, opd;
      op = m_ir[7:4];
      opd = m_ir[3:0];
      o = '0;
      o.alu_op = op[2:0];
      o.alu_shamt = opd;
      o.nibble_out = opd;
      o.reg_sel = opd;
      o.addr_offset = opd;
      o.reg16_dst = opd[3:2];
      o.reg16_src = opd[1:0];
      o.nibble_hl = (op == 4'd13);
      o.flags = m_flags;
      o.branch = m_branch;
      if (m_halt) begin
         o.fault = 1'b1;
      end else if (!m_busy) begin
         o.instr_ready = 1'b1;
      end else if (m_age == 2) begin
         o.alu_en = (op < 4'd8);
         o.jmp = (op == 4'd8);
         o.jpl = (op == 4'd9);
         o.mva = (op == 4'd10);
         o.mvb = (op == 4'd11);
         o.nibble_read = (op == 4'd12) || (op == 4'd13);
         o.pc_inc = (op < 4'd14);
      end else if (m_age >= 3) begin
         o.mem_req = 1'b1;
         o.we = (op == 4'd15);
         o.pc_inc = mem_ack;
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_halt <= 1'b0;
         m_busy <= 1'b0;
         m_age <= 0;
         m_ir <= 8'h00;
         m_flags <= 4'h0;
         m_branch <= 1'b0;
         m_alu_prev <= 1'b0;
      end else begin
         if (m_alu_prev) m_flags <= alu_flags;
         m_alu_prev <= model_alu_strobe();
         if (!m_halt) begin
            if (!m_busy) begin
               if (instr_valid) begin
                  m_busy <= 1'b1;
                  m_age <= 1;
                  m_ir <= instr;
               end
            end else if (m_age == 1) begin
               m_branch <= cond_ref(m_ir[3:0], m_flags);
               m_age <= 2;
            end else if (m_age == 2) begin
               if (m_ir[7:4] >= 4'd14) m_age <= 3;
               else m_busy <= 1'b0;
            end else if (mem_ack) begin
               m_busy <= 1'b0;
            end else if (m_age - 2 == MEM_TIMEOUT) begin
               m_halt <= 1'b1;
               m_busy <= 1'b0;
            end else begin
               m_age <= m_age + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      outs_t e;
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            e = expect_now();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, e);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] r);
      checks++;
      if (a !== r) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, a, r);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] ins, input bit ack, input logic [3:0] fl);
      @(negedge clk);
      instr_valid = v;
      instr = ins;
      mem_ack = ack;
      alu_flags = fl;
      #3;
   endtask

   // Runs one memory instruction; ack_on = n acks in the n-th MEM cycle, 0 never.
   task automatic mem_txn(input logic [7:0] ins, input int ack_on,
                          output int total, output int mreq, output int weq, output int pci);
      bit fin;
      total = 1; mreq = 0; weq = 0; pci = 0; fin = 1'b0;
      step(1'b1, ins, 1'b0, 4'h0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 8'h00, (ack_on != 0) && (mreq == ack_on - 1), 4'h0);
         if (instr_ready || fault) begin
            fin = 1'b1;
            break;
         end
         total++;
         if (mem_req) mreq++;
         if (we) weq++;
         if (pc_inc) pci++;
      end
      chk("mem_txn_finished", 32'(fin), 32'd1);
   endtask

   // ALU op, present flags f in the following cycle, then JMP with condition cc.
   task automatic run_cond(input logic [3:0] cc, input logic [3:0] f, output bit br, output bit j);
      step(1'b1, 8'h20, 1'b0, 4'h0);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      step(1'b1, {4'h8, cc}, 1'b0, f);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      br = branch;
      j = jmp;
   endtask

   // ---------------- main sequence ----------------
   logic [8:0] pins [8];

   initial begin
      int total, mreq, weq, pci, jcnt;
      bit br, j;
      pins = '{ {4'd12, 4'b1100, 1'b1}, {4'd12, 4'b1101, 1'b0}, {4'd13, 4'b0001, 1'b1},
                {4'd8,  4'b0011, 1'b0}, {4'd8,  4'b0010, 1'b1}, {4'd11, 4'b0100, 1'b1},
                {4'd10, 4'b1000, 1'b0}, {4'd9,  4'b0000, 1'b1} };

      rst_n = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 4'h0);
      chk("reset_instr_ready", 32'(instr_ready), 32'd1);
      chk("reset_flags_q", 32'(flags_q), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);

      // Idle FETCH: nothing fires, state holds.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'hF3, 1'b1, 4'hF);
         chk("idle_instr_ready", 32'(instr_ready), 32'd1);
         chk("idle_strobes", 32'({alu_en, pc_inc, mem_req, jmp, nibble_read}), 32'd0);
      end

      // ALU op, Z presented, then JMP EQ.
      step(1'b1, 8'h10, 1'b0, 4'h0);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      step(1'b0, 8'h00, 1'b0, 4'h0);
      chk("alu_en_exec", 32'(alu_en), 32'd1);
      step(1'b0, 8'h00, 1'b0, 4'b0001);
      step(1'b1, 8'h80, 1'b0, 4'h0);
      chk("flags_q_z", 32'(flags_q[0]), 32'd1);
      jcnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b0, 4'h0);
         if (jmp) jcnt++;
         if (i == 1) chk("branch_eq", 32'(branch), 32'd1);
      end
      chk("jmp_pulse_count", 32'(jcnt), 32'd1);

      // STB acked in the 4th MEM cycle.
      mem_txn(8'hF5, 4, total, mreq, weq, pci);
      chk("stb_total_cycles", 32'(total), 32'd7);
      chk("stb_mem_req_cycles", 32'(mreq), 32'd4);
      chk("stb_we_cycles", 32'(weq), 32'd4);
      chk("stb_pc_inc", 32'(pci), 32'd1);

      // Ack in the last allowed MEM cycle wins over the timeout.
      mem_txn(8'hE2, 15, total, mreq, weq, pci);
      chk("ack_at_limit_total", 32'(total), 32'd18);
      chk("ack_at_limit_pc_inc", 32'(pci), 32'd1);
      chk("ack_at_limit_we", 32'(weq), 32'd0);
      chk("ack_at_limit_fault", 32'(fault), 32'd0);

      // Reset while a load is in MEM.
      step(1'b1, 8'hE3, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 4'h0);
      chk("mid_mem_req", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      step(1'b0, 8'h00, 1'b0, 4'h0);
      rst_n = 1'b1;
      chk("mid_mem_reset_ready", 32'(instr_ready), 32'd1);
      chk("mid_mem_reset_req", 32'(mem_req), 32'd0);
      chk("mid_mem_reset_fault", 32'(fault), 32'd0);

      // LDB never acknowledged: timeout into HALT.
      mem_txn(8'hE7, 0, total, mreq, weq, pci);
      chk("timeout_mem_cycles", 32'(mreq), 32'd15);
      chk("timeout_pc_inc", 32'(pci), 32'd0);
      chk("timeout_fault", 32'(fault), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h10, 1'b1, 4'h0);
         chk("halt_fault_sticky", 32'(fault), 32'd1);
         chk("halt_no_accept", 32'({instr_ready, alu_en, pc_inc, mem_req}), 32'd0);
      end
      rst_n = 1'b0;
      step(1'b0, 8'h00, 1'b0, 4'h0);
      rst_n = 1'b1;
      chk("halt_reset_fault", 32'(fault), 32'd0);
      chk("halt_reset_ready", 32'(instr_ready), 32'd1);

      // Hand-computed condition results.
      for (int i = 0; i < 8; i++) begin
         run_cond(pins[i][8:5], pins[i][4:1], br, j);
         chk($sformatf("pin_cc%0d_f%0h", pins[i][8:5], pins[i][4:1]), 32'(br), 32'(pins[i][0]));
      end

      // Full condition sweep.
      for (int cc = 0; cc < 16; cc++) begin
         for (int f = 0; f < 16; f++) begin
            run_cond(4'(cc), 4'(f), br, j);
            chk($sformatf("sweep_cc%0d_f%0h", cc, f), 32'(br), 32'(cond_ref(4'(cc), 4'(f))));
            chk("sweep_jmp", 32'(j), 32'd1);
            if (cc == 14) chk("sweep_al", 32'(br), 32'd1);
            if (cc == 15) chk("sweep_nv", 32'(br), 32'd0);
         end
      end

      // Randomized traffic, checked by the per-cycle compare.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 199) != 0);
         instr_valid = ($urandom_range(0, 9) < 6);
         instr = 8'($urandom);
         mem_ack = ($urandom_range(0, 9) < 3);
         alu_flags = 4'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
      instr_valid = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
